// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and register-file control encodings for the
//               instruction fetch sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  // Fetch sequencer states: idle, low-byte read, high-byte read, completion.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RD_LO = 2'b01,
    RD_HI = 2'b10,
    DONE  = 2'b11
  } fetch_state_e;

  // Register file FunSel codes.
  localparam logic [1:0] FUNSEL_HOLD = 2'b00;
  localparam logic [1:0] FUNSEL_INC  = 2'b01;

  // Register file RegSel enables: bit2=PC, bit1=SP, bit0=AR.
  localparam logic [2:0] REGSEL_NONE = 3'b000;
  localparam logic [2:0] REGSEL_PC   = 3'b100;

  // Register file OutDSel code that places PC on OutD.
  localparam logic [1:0] OUTDSEL_PC  = 2'b00;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_wait_timer
// Description : Per-byte memory wait counter. Counts cycles while enabled and
//               flags expiry on the LIMIT-th consecutive waiting cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_wait_timer #(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear wins over counting a wait cycle.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Wait counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The current cycle is the LIMIT-th waiting cycle when LIMIT-1 are already counted.
  assign expired_o = enable_i && (count_q == CNT_W'(LIMIT - 1));

endmodule : fetch_wait_timer
`default_nettype wire

// File: rtl/instr_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_sequencer
// Description : Fetches one 16-bit instruction as two little-endian byte reads
//               addressed by PC from the address register file, incrementing
//               PC once per accepted byte. Optional per-byte wait timeout is
//               enabled by defining FETCH_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                flush_i,
  input  logic [ADDR_W-1:0]   pc_addr_i,
  output logic [1:0]          arf_funsel_o,
  output logic [2:0]          arf_regsel_o,
  output logic [1:0]          arf_outdsel_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic                mem_req_o,
  input  logic                mem_ack_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic [2*DATA_W-1:0] ir_o,
  output logic                ir_valid_o,
  output logic                busy_o,
  output logic                fetch_err_o
);

  fetch_state_e        state_q;
  logic [DATA_W-1:0]   lo_byte_q;
  logic [2*DATA_W-1:0] ir_q;
  logic                ir_valid_q;
  logic                mem_req_q;
  logic                busy_q;
  logic                fetch_err_q;

  logic                in_read;
  logic                byte_accept;
  logic                timeout_hit;

  // A byte is accepted only on an ack during a read state that is not being flushed.
  assign in_read     = (state_q == RD_LO) || (state_q == RD_HI);
  assign byte_accept = in_read && mem_ack_i && !flush_i;

`ifdef FETCH_TIMEOUT_EN
  logic timer_clear;
  logic timer_enable;

  // Restart the count whenever a read state is entered.
  assign timer_clear  = ((state_q == IDLE) && start_i) || ((state_q == RD_LO) && byte_accept);
  assign timer_enable = mem_req_q && !mem_ack_i;

  fetch_wait_timer #(
    .LIMIT     (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (timer_clear),
    .enable_i  (timer_enable),
    .expired_o (timeout_hit)
  );
`else
  logic unused_timeout_cfg;

  assign timeout_hit        = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  // Fetch FSM with registered request, busy, completion and error flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      lo_byte_q   <= '0;
      ir_q        <= '0;
      ir_valid_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      busy_q      <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      ir_valid_q  <= 1'b0;
      fetch_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q   <= RD_LO;
            mem_req_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        RD_LO: begin
          if (flush_i) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            busy_q    <= 1'b0;
          end else if (mem_ack_i) begin
            lo_byte_q <= mem_rdata_i;
            state_q   <= RD_HI;
          end else if (timeout_hit) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            busy_q      <= 1'b0;
            fetch_err_q <= 1'b1;
          end
        end
        RD_HI: begin
          if (flush_i) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            busy_q    <= 1'b0;
          end else if (mem_ack_i) begin
            ir_q       <= {mem_rdata_i, lo_byte_q};
            ir_valid_q <= 1'b1;
            mem_req_q  <= 1'b0;
            state_q    <= DONE;
          end else if (timeout_hit) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            busy_q      <= 1'b0;
            fetch_err_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  // PC increments on the same edge that accepts a byte; otherwise the register file holds.
  assign arf_regsel_o  = byte_accept ? REGSEL_PC  : REGSEL_NONE;
  assign arf_funsel_o  = byte_accept ? FUNSEL_INC : FUNSEL_HOLD;
  assign arf_outdsel_o = OUTDSEL_PC;

  assign mem_addr_o  = pc_addr_i;
  assign mem_req_o   = mem_req_q;
  assign ir_o        = ir_q;
  assign ir_valid_o  = ir_valid_q;
  assign busy_o      = busy_q;
  assign fetch_err_o = fetch_err_q;

endmodule : instr_fetch_sequencer
`default_nettype wire

// File: tb/tb_instr_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_sequencer
// Description : Self-checking bench for instr_fetch_sequencer with a register
//               file model, a wait-state memory responder and a schedule-based
//               reference model. Timeout scenarios run when FETCH_TIMEOUT_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        start_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [15:0] pc_addr_i;
  logic [1:0]  arf_funsel_o;
  logic [2:0]  arf_regsel_o;
  logic [1:0]  arf_outdsel_o;
  logic [15:0] mem_addr_o;
  logic        mem_req_o;
  logic        mem_ack_i = 1'b0;
  logic [7:0]  mem_rdata_i = 8'h00;
  logic [15:0] ir_o;
  logic        ir_valid_o;
  logic        busy_o;
  logic        fetch_err_o;

  always #5 clk_i = ~clk_i;

  instr_fetch_sequencer dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .start_i       (start_i),
    .flush_i       (flush_i),
    .pc_addr_i     (pc_addr_i),
    .arf_funsel_o  (arf_funsel_o),
    .arf_regsel_o  (arf_regsel_o),
    .arf_outdsel_o (arf_outdsel_o),
    .mem_addr_o    (mem_addr_o),
    .mem_req_o     (mem_req_o),
    .mem_ack_i     (mem_ack_i),
    .mem_rdata_i   (mem_rdata_i),
    .ir_o          (ir_o),
    .ir_valid_o    (ir_valid_o),
    .busy_o        (busy_o),
    .fetch_err_o   (fetch_err_o)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk_i) cyc <= cyc + 1;

  // Register file model: PC loadable by the bench, incremented on FunSel=INC with RegSel PC bit.
  logic [15:0] pc = 16'h0000;
  logic        pc_load = 1'b0;
  logic [15:0] pc_load_val = 16'h0000;
  always @(posedge clk_i) begin
    if (pc_load) pc <= pc_load_val;
    else if (arf_regsel_o == 3'b100 && arf_funsel_o == 2'b01) pc <= pc + 16'h0001;
  end
  assign pc_addr_i = (arf_outdsel_o == 2'b00) ? pc : 16'hxxxx;

  // Byte memory with a fixed number of wait cycles before each ack.
  logic [7:0] mem [0:65535];
  int wait_cfg = 0;
  int wcnt = 0;
  always @(posedge clk_i) begin
    if (!mem_req_o || mem_ack_i) wcnt = 0;
    else wcnt++;
    #1;
    if (mem_req_o && wcnt == wait_cfg) begin
      mem_ack_i   = 1'b1;
      mem_rdata_i = mem[mem_addr_o];
    end else begin
      mem_ack_i   = 1'b0;
      mem_rdata_i = 8'h00;
    end
  end

  // Observers for pulse counts and timing.
  int rs_cnt = 0, valid_cnt = 0, err_cnt = 0, last_valid_cyc = -1, last_err_cyc = -1;
  always @(negedge clk_i) begin
    if (arf_regsel_o == 3'b100) rs_cnt++;
    if (ir_valid_o) begin valid_cnt++; last_valid_cyc = cyc; end
    if (fetch_err_o) begin err_cnt++; last_err_cyc = cyc; end
  end

  // Reference model: one fetch described by its start cycle, per-byte wait,
  // starting PC, resulting IR and optional flush / timeout cycle.
  bit          m_act = 1'b0;
  int          m_e = 0, m_w = 0, m_flush = -1, m_to = -1;
  logic [15:0] m_pc0 = 16'h0, m_ir_old = 16'h0, m_ir_new = 16'h0;

  function automatic void expect_at(input int c, output logic busy, output logic req,
                                    output logic valid, output logic err, output logic [2:0] rs,
                                    output logic [15:0] addr, output logic [15:0] ir);
    int lo, hi, dn, stop;
    busy = 0; req = 0; valid = 0; err = 0; rs = 3'b000; addr = 16'h0; ir = m_ir_old;
    if (!m_act) return;
    lo = m_e + m_w;
    hi = lo + 1 + m_w;
    dn = hi + 1;
    stop = (m_flush >= 0) ? m_flush : (m_to >= 0) ? m_to : dn;
    if (m_to >= 0 && c == m_to + 1) err = 1;
    if (m_flush < 0 && m_to < 0 && c >= dn) ir = m_ir_new;
    if (c < m_e || c > stop) return;
    busy = 1;
    if (c <= hi) begin
      req  = 1;
      addr = 16'(m_pc0 + ((c > lo) ? 16'd1 : 16'd0));
      if ((c == lo || c == hi) && c != m_flush) rs = 3'b100;
    end
    if (c == dn) valid = 1;
  endfunction

  // Per-cycle comparison of every output against the model.
  always @(negedge clk_i) begin
    logic eb, er, ev, ee;
    logic [2:0] ers;
    logic [15:0] ea, ei;
    if (check_en && rst_ni) begin
      expect_at(cyc, eb, er, ev, ee, ers, ea, ei);
      chk("busy", 32'(busy_o), 32'(eb));
      chk("mem_req", 32'(mem_req_o), 32'(er));
      chk("ir_valid", 32'(ir_valid_o), 32'(ev));
      chk("fetch_err", 32'(fetch_err_o), 32'(ee));
      chk("regsel", 32'(arf_regsel_o), 32'(ers));
      chk("funsel", 32'(arf_funsel_o), (ers == 3'b100) ? 32'd1 : 32'd0);
      chk("outdsel", 32'(arf_outdsel_o), 32'd0);
      chk("ir", 32'(ir_o), 32'(ei));
      if (er) chk("mem_addr", 32'(mem_addr_o), 32'(ea));
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_pc(input logic [15:0] v);
    pc_load_val = v;
    pc_load = 1'b1;
    tick();
    pc_load = 1'b0;
  endtask

  task automatic model_start(input int e, input int w, input logic [15:0] pc0, input logic [15:0] irn);
    logic b, r, v, er;
    logic [2:0] rs;
    logic [15:0] a, i;
    expect_at(cyc, b, r, v, er, rs, a, i);
    m_ir_old = i;
    m_act = 1'b1; m_e = e; m_w = w; m_pc0 = pc0; m_ir_new = irn; m_flush = -1; m_to = -1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy_o && n < 200) begin tick(); n++; end
    chk({name, "_idle_timeout"}, 32'(busy_o), 32'd0);
  endtask

  // Issue one fetch; returns the cycle in which start was driven.
  task automatic do_fetch(input int w, input logic [15:0] irn, output int drv);
    wait_cfg = w;
    drv = cyc;
    model_start(drv + 1, w, pc, irn);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  initial begin
    int drv;
    mem[16'h0100] = 8'h34; mem[16'h0101] = 8'h12;
    mem[16'hFFFF] = 8'hCD; mem[16'h0000] = 8'hAB;
    mem[16'h0200] = 8'h78; mem[16'h0201] = 8'h56;
    mem[16'h0300] = 8'h9A; mem[16'h0301] = 8'hBC;

    // Reset state.
    #1 rst_ni = 1'b0;
    #2;
    chk("rst_ir", 32'(ir_o), 32'h0);
    chk("rst_ir_valid", 32'(ir_valid_o), 32'h0);
    chk("rst_mem_req", 32'(mem_req_o), 32'h0);
    chk("rst_regsel", 32'(arf_regsel_o), 32'h0);
    chk("rst_funsel", 32'(arf_funsel_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_fetch_err", 32'(fetch_err_o), 32'h0);
    tick(); tick();
    rst_ni = 1'b1;
    check_en = 1'b1;

    // Zero-wait fetch.
    set_pc(16'h0100);
    rs_cnt = 0;
    do_fetch(0, 16'h1234, drv);
    wait_idle("zw");
    chk("zw_ir", 32'(ir_o), 32'h1234);
    chk("zw_pc", 32'(pc), 32'h0102);
    chk("zw_regsel_cycles", 32'(rs_cnt), 32'd2);
    chk("zw_valid_latency", 32'(last_valid_cyc - drv), 32'd3);

    // PC wrap.
    set_pc(16'hFFFF);
    do_fetch(0, 16'hABCD, drv);
    wait_idle("wrap");
    chk("wrap_ir", 32'(ir_o), 32'hABCD);
    chk("wrap_pc", 32'(pc), 32'h0001);

    // Three wait cycles per byte.
    set_pc(16'h0100);
    rs_cnt = 0;
    do_fetch(3, 16'h1234, drv);
    wait_idle("ws");
    chk("ws_ir", 32'(ir_o), 32'h1234);
    chk("ws_pc", 32'(pc), 32'h0102);
    chk("ws_regsel_cycles", 32'(rs_cnt), 32'd2);
    chk("ws_valid_latency", 32'(last_valid_cyc - drv), 32'd9);

    // Flush in RD_HI together with ack; start while busy is ignored.
    set_pc(16'h0100);
    valid_cnt = 0;
    do_fetch(2, 16'h1234, drv);
    m_flush = m_e + 5;
    while (cyc < m_e + 1) tick();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    while (cyc < m_flush) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("fl_busy_next", 32'(busy_o), 32'h0);
    chk("fl_pc", 32'(pc), 32'h0101);
    chk("fl_ir", 32'(ir_o), 32'h1234);
    tick(); tick();
    chk("fl_no_valid", 32'(valid_cnt), 32'd0);
    chk("fl_stays_idle", 32'(busy_o), 32'h0);

    // Asynchronous reset in RD_LO while waiting.
    set_pc(16'h0200);
    do_fetch(5, 16'h5678, drv);
    while (cyc < m_e + 2) tick();
    rst_ni = 1'b0;
    m_act = 1'b0;
    m_ir_old = 16'h0000;
    #1;
    chk("ar_mem_req", 32'(mem_req_o), 32'h0);
    chk("ar_busy", 32'(busy_o), 32'h0);
    chk("ar_regsel", 32'(arf_regsel_o), 32'h0);
    chk("ar_ir", 32'(ir_o), 32'h0);
    tick(); tick();
    rst_ni = 1'b1;
    tick();
    chk("ar_pc", 32'(pc), 32'h0200);
    do_fetch(0, 16'h5678, drv);
    wait_idle("ar_refetch");
    chk("ar_refetch_ir", 32'(ir_o), 32'h5678);
    chk("ar_refetch_pc", 32'(pc), 32'h0202);

`ifdef FETCH_TIMEOUT_EN
    // No ack: fetch_err after 15 waiting cycles, PC and IR untouched.
    set_pc(16'h0300);
    err_cnt = 0;
    do_fetch(1000, 16'h0000, drv);
    m_to = m_e + 14;
    wait_idle("to");
    tick(); tick();
    chk("to_err_count", 32'(err_cnt), 32'd1);
    chk("to_err_latency", 32'(last_err_cyc - drv), 32'd16);
    chk("to_pc", 32'(pc), 32'h0300);
    chk("to_ir", 32'(ir_o), 32'h5678);

    // Ack in the 15th waiting cycle is accepted.
    err_cnt = 0;
    do_fetch(14, 16'hBC9A, drv);
    wait_idle("to_edge");
    tick();
    chk("to_edge_err_count", 32'(err_cnt), 32'd0);
    chk("to_edge_ir", 32'(ir_o), 32'hBC9A);
    chk("to_edge_pc", 32'(pc), 32'h0302);
`endif

    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_instr_fetch_sequencer
`default_nettype wire
